// File: rtl/ray_grid_stepper_pkg.sv
`default_nettype none
// ============================================================================
// Package : ray_pkg
// Brief   : Shared state encoding, mode constants and cell helper for the
//           ray grid stepper.
// Rev     : 1.0
// ============================================================================
package ray_pkg;

  localparam logic [2:0] S_WAIT     = 3'd0;
  localparam logic [2:0] S_FIRST    = 3'd1;
  localparam logic [2:0] S_OFFSET   = 3'd2;
  localparam logic [2:0] S_BOUND    = 3'd3;
  localparam logic [2:0] S_MAP_WAIT = 3'd4;
  localparam logic [2:0] S_STEP     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic MODE_HORIZ = 1'b0;
  localparam logic MODE_VERT  = 1'b1;

  function automatic int CELL_SIZE(input int cell_log2);
    return 1 << cell_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ray_grid_stepper_if.sv
`default_nettype none
// ============================================================================
// Interface : ray_grid_stepper_if
// Brief     : Request/result bundle between the column sequencer and stepper.
// Rev       : 1.0
// ============================================================================
interface ray_grid_stepper_if #(
  parameter int W    = 12,
  parameter int FRAC = 8,
  parameter int SC_W = 5
);
  logic                     begin_calc;
  logic                     mode;
  logic                     dir_pos;
  logic signed [W+FRAC-1:0] slope;
  logic [W-1:0]             playerX;
  logic [W-1:0]             playerY;
  logic [W-1:0]             wallX;
  logic [W-1:0]             wallY;
  logic                     wall_found;
  logic [SC_W-1:0]          step_count;
  logic                     busy;
  logic                     end_calc;

  modport slave (
    input  begin_calc, mode, dir_pos, slope, playerX, playerY,
    output wallX, wallY, wall_found, step_count, busy, end_calc
  );

  modport master (
    output begin_calc, mode, dir_pos, slope, playerX, playerY,
    input  wallX, wallY, wall_found, step_count, busy, end_calc
  );
endinterface
`default_nettype wire

// File: rtl/ray_grid_stepper_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ray_stepper_ctrl
// Brief  : Sequencing FSM: map-latency counter, step counter and end reason.
// Rev    : 1.0
// ============================================================================
module ray_stepper_ctrl
  import ray_pkg::*;
#(
  parameter int MAX_STEPS = 16,
  parameter int MAP_LAT   = 1,
  parameter int SC_W      = 5
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            i_begin,
  input  logic            i_in_bounds,
  input  logic            i_map_wall,
  output logic [2:0]      o_state,
  output logic            o_accept,
  output logic            o_rd_en,
  output logic            o_busy,
  output logic            o_end_calc,
  output logic            o_wall_found,
  output logic [SC_W-1:0] o_step_count
);

  localparam int LAT_W = $clog2(MAP_LAT + 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [LAT_W-1:0] r_lat;
  logic            r_wall_found;
  logic [SC_W-1:0] r_steps;
  logic            w_lat_last;
  logic            w_at_limit;

  always_comb begin
    w_lat_last = (r_lat == LAT_W'(MAP_LAT));
    w_at_limit = (r_steps == SC_W'(MAX_STEPS));
    w_next     = r_state;
    case (r_state)
      S_WAIT:     if (i_begin) w_next = S_FIRST;
      S_FIRST:    w_next = S_OFFSET;
      S_OFFSET:   w_next = S_BOUND;
      S_BOUND:    w_next = i_in_bounds ? S_MAP_WAIT : S_DONE;
      S_MAP_WAIT: if (w_lat_last) w_next = (i_map_wall || w_at_limit) ? S_DONE : S_STEP;
      S_STEP:     w_next = S_BOUND;
      S_DONE:     w_next = S_WAIT;
      default:    w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_WAIT;
      r_lat        <= '0;
      r_wall_found <= 1'b0;
      r_steps      <= '0;
    end else begin
      r_state <= w_next;

      // Counter is armed by the read strobe so the wall bit is taken exactly MAP_LAT cycles later
      if (r_state == S_BOUND)
        r_lat <= LAT_W'(1);
      else if (r_state == S_MAP_WAIT && !w_lat_last)
        r_lat <= r_lat + LAT_W'(1);

      if (o_accept)
        r_wall_found <= 1'b0;
      else if (r_state == S_MAP_WAIT && w_lat_last && i_map_wall)
        r_wall_found <= 1'b1;

      if (o_accept)
        r_steps <= '0;
      else if (r_state == S_STEP)
        r_steps <= r_steps + SC_W'(1);
    end
  end

  assign o_state      = r_state;
  assign o_accept     = (r_state == S_WAIT) && i_begin;
  assign o_rd_en      = (r_state == S_BOUND) && i_in_bounds;
  assign o_busy       = (r_state != S_WAIT);
  assign o_end_calc   = (r_state == S_DONE);
  assign o_wall_found = r_wall_found;
  assign o_step_count = r_steps;

endmodule
`default_nettype wire

// File: rtl/ray_grid_stepper.sv
`default_nettype none
// ============================================================================
// Module : ray_grid_stepper
// Brief  : Walks a ray across grid lines of one axis, querying the maze map
//          until a wall, the maze edge or the step limit is reached.
// Rev    : 1.0
// ============================================================================
module ray_grid_stepper
  import ray_pkg::*;
#(
  parameter int W         = 12,
  parameter int CELL_LOG2 = 6,
  parameter int MAP_COLS  = 8,
  parameter int MAP_ROWS  = 8,
  parameter int FRAC      = 8,
  parameter int MAX_STEPS = 16,
  parameter int MAP_LAT   = 1,
  localparam int COL_W    = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1,
  localparam int ROW_W    = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1,
  localparam int SC_W     = $clog2(MAX_STEPS + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  ray_grid_stepper_if.slave s_ray,
  output logic             o_map_rd_en,
  output logic [COL_W-1:0] o_map_col,
  output logic [ROW_W-1:0] o_map_row,
  input  logic             i_map_wall
);

  localparam int WI = W + 2;
  localparam int PW = WI + W + FRAC;
  localparam int DW = W + FRAC + CELL_LOG2 + 1;

  localparam logic signed [WI-1:0] c_CELL      = WI'(CELL_SIZE(CELL_LOG2));
  localparam logic signed [WI-1:0] c_CELL_MASK = ~(c_CELL - WI'(1));
  localparam logic signed [WI-1:0] c_X_LIM     = WI'(MAP_COLS * CELL_SIZE(CELL_LOG2));
  localparam logic signed [WI-1:0] c_Y_LIM     = WI'(MAP_ROWS * CELL_SIZE(CELL_LOG2));

  logic [2:0]               w_state;
  logic                     w_accept;
  logic                     w_in_bounds;
  logic                     w_wall_found;
  logic [SC_W-1:0]          w_step_count;
  logic                     w_busy;
  logic                     w_end_calc;

  logic                     r_mode;
  logic                     r_dir;
  logic signed [W+FRAC-1:0] r_slope;
  logic [W-1:0]             r_px;
  logic [W-1:0]             r_py;
  logic signed [WI-1:0]     r_s;
  logic signed [WI-1:0]     r_o;
  logic signed [WI-1:0]     r_ds;
  logic signed [WI-1:0]     r_do;

  logic signed [WI-1:0]     w_s_in;
  logic signed [WI-1:0]     w_o_in;
  logic signed [WI-1:0]     w_base;
  logic signed [WI-1:0]     w_s1;
  logic signed [WI-1:0]     w_delta;
  logic signed [WI-1:0]     w_o1;
  logic signed [WI-1:0]     w_x;
  logic signed [WI-1:0]     w_y;
  logic signed [PW-1:0]     w_prod;
  logic signed [DW-1:0]     w_slope_dir;
  logic signed [DW-1:0]     w_do_full;

  ray_stepper_ctrl #(
    .MAX_STEPS (MAX_STEPS),
    .MAP_LAT   (MAP_LAT),
    .SC_W      (SC_W)
  ) u_ctrl (
    .clock        (clock),
    .resetn       (resetn),
    .i_begin      (s_ray.begin_calc),
    .i_in_bounds  (w_in_bounds),
    .i_map_wall   (i_map_wall),
    .o_state      (w_state),
    .o_accept     (w_accept),
    .o_rd_en      (o_map_rd_en),
    .o_busy       (w_busy),
    .o_end_calc   (w_end_calc),
    .o_wall_found (w_wall_found),
    .o_step_count (w_step_count)
  );

  // First crossing: only this path multiplies; the per-step offset is shift-only
  always_comb begin
    w_s_in      = (r_mode == MODE_VERT) ? WI'(r_px) : WI'(r_py);
    w_o_in      = (r_mode == MODE_VERT) ? WI'(r_py) : WI'(r_px);
    w_base      = w_s_in & c_CELL_MASK;
    w_s1        = r_dir ? (w_base + c_CELL) : (w_base - WI'(1));
    w_delta     = w_s1 - w_s_in;
    w_prod      = PW'(w_delta) * PW'(r_slope);
    w_o1        = w_o_in + WI'(w_prod >>> FRAC);
    w_slope_dir = r_dir ? DW'(r_slope) : -DW'(r_slope);
    w_do_full   = (w_slope_dir <<< CELL_LOG2) >>> FRAC;
  end

  always_comb begin
    w_x         = (r_mode == MODE_VERT) ? r_s : r_o;
    w_y         = (r_mode == MODE_VERT) ? r_o : r_s;
    w_in_bounds = !w_x[WI-1] && !w_y[WI-1] && (w_x < c_X_LIM) && (w_y < c_Y_LIM);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mode  <= 1'b0;
      r_dir   <= 1'b0;
      r_slope <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_s     <= '0;
      r_o     <= '0;
      r_ds    <= '0;
      r_do    <= '0;
    end else begin
      if (w_accept) begin
        r_mode  <= s_ray.mode;
        r_dir   <= s_ray.dir_pos;
        r_slope <= s_ray.slope;
        r_px    <= s_ray.playerX;
        r_py    <= s_ray.playerY;
      end
      case (w_state)
        S_FIRST: begin
          r_s <= w_s1;
          r_o <= w_o1;
        end
        S_OFFSET: begin
          r_ds <= r_dir ? c_CELL : -c_CELL;
          r_do <= WI'(w_do_full);
        end
        S_STEP: begin
          r_s <= r_s + r_ds;
          r_o <= r_o + r_do;
        end
        default: ;
      endcase
    end
  end

  assign o_map_col = o_map_rd_en ? w_x[CELL_LOG2 +: COL_W] : '0;
  assign o_map_row = o_map_rd_en ? w_y[CELL_LOG2 +: ROW_W] : '0;

  assign s_ray.wallX      = w_x[W-1:0];
  assign s_ray.wallY      = w_y[W-1:0];
  assign s_ray.wall_found = w_wall_found;
  assign s_ray.step_count = w_step_count;
  assign s_ray.busy       = w_busy;
  assign s_ray.end_calc   = w_end_calc;

endmodule
`default_nettype wire

// File: tb/tb_ray_grid_stepper.sv
`default_nettype none
// ============================================================================
// Module : tb_ray_grid_stepper
// Brief  : Two steppers (default and MAX_STEPS=2) against a plain ray-march model.
// Rev    : 1.0
// ============================================================================
module tb_ray_grid_stepper;

  localparam int W       = 12;
  localparam int FRAC    = 8;
  localparam int CELL    = 64;
  localparam int MAP_LAT = 1;
  localparam int LIM0    = 16;
  localparam int LIM1    = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ray_grid_stepper_if #(.W(W), .FRAC(FRAC), .SC_W($clog2(LIM0 + 1))) rif0 ();
  ray_grid_stepper_if #(.W(W), .FRAC(FRAC), .SC_W($clog2(LIM1 + 1))) rif1 ();

  logic       rd0, rd1, mw0, mw1;
  logic [2:0] col0, row0, col1, row1;

  ray_grid_stepper #(.MAX_STEPS(LIM0), .MAP_LAT(MAP_LAT)) u_dut0 (
    .clock(clock), .resetn(resetn), .s_ray(rif0.slave),
    .o_map_rd_en(rd0), .o_map_col(col0), .o_map_row(row0), .i_map_wall(mw0)
  );
  ray_grid_stepper #(.MAX_STEPS(LIM1), .MAP_LAT(MAP_LAT)) u_dut1 (
    .clock(clock), .resetn(resetn), .s_ray(rif1.slave),
    .o_map_rd_en(rd1), .o_map_col(col1), .o_map_row(row1), .i_map_wall(mw1)
  );

  // Map memory: valid one cycle after the strobe, noise on every other cycle
  bit   map_mem [8][8];
  logic v0, d0, n0, v1, d1, n1;
  always @(posedge clock) begin
    v0 <= rd0; d0 <= map_mem[row0][col0]; n0 <= 1'($urandom);
    v1 <= rd1; d1 <= map_mem[row1][col1]; n1 <= 1'($urandom);
  end
  assign mw0 = v0 ? d0 : n0;
  assign mw1 = v1 ? d1 : n1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int c0 = 0;
  int rdq0[$];
  int rdq1[$];
  int n_end[2];
  int lat[2];
  int obs_wx[2], obs_wy[2], obs_f[2], obs_s[2];

  always @(negedge clock) begin
    if (resetn) begin
      if (rd0) rdq0.push_back(int'({row0, col0}));
      if (rd1) rdq1.push_back(int'({row1, col1}));
      if (rif0.end_calc) begin
        n_end[0]++; lat[0] = cyc - c0 + 1;
        obs_wx[0] = int'(rif0.wallX); obs_wy[0] = int'(rif0.wallY);
        obs_f[0] = int'(rif0.wall_found); obs_s[0] = int'(rif0.step_count);
      end
      if (rif1.end_calc) begin
        n_end[1]++; lat[1] = cyc - c0 + 1;
        obs_wx[1] = int'(rif1.wallX); obs_wy[1] = int'(rif1.wallY);
        obs_f[1] = int'(rif1.wall_found); obs_s[1] = int'(rif1.step_count);
      end
    end
  end

  function automatic longint wrapw(input longint v);
    longint m;
    m = v & ((longint'(1) << (W + 2)) - 1);
    if (m >= (longint'(1) << (W + 1))) m = m - (longint'(1) << (W + 2));
    return m;
  endfunction

  // March the ray crossing by crossing with ordinary integer arithmetic
  task automatic ref_model(input bit mode, input bit dir, input longint slope,
                           input longint px, input longint py, input int maxs,
                           output int wx, output int wy, output int found,
                           output int steps, output int latency, output int reads[$]);
    longint s, o, b, s1, ds, dof, x, y;
    int n;
    reads = {};
    s = mode ? px : py;
    o = mode ? py : px;
    b = (s / CELL) * CELL;
    s1 = dir ? b + CELL : b - 1;
    o = wrapw(o + (((s1 - s) * slope) >>> FRAC));
    s = wrapw(s1);
    ds = dir ? CELL : -CELL;
    dof = wrapw(((dir ? slope : -slope) * CELL) >>> FRAC);
    n = 0; found = 0; latency = 0; x = 0; y = 0;
    for (int k = 0; k < 200; k++) begin
      x = mode ? s : o;
      y = mode ? o : s;
      if (x < 0 || y < 0 || x >= 8 * CELL || y >= 8 * CELL) begin
        latency = 4 + n * (2 + MAP_LAT);
        break;
      end
      reads.push_back(int'((y / CELL) * 8 + (x / CELL)));
      if (map_mem[int'(y / CELL)][int'(x / CELL)]) begin
        found = 1;
        latency = 4 + MAP_LAT + n * (2 + MAP_LAT);
        break;
      end
      if (n == maxs) begin
        latency = 4 + MAP_LAT + n * (2 + MAP_LAT);
        break;
      end
      s = wrapw(s + ds);
      o = wrapw(o + dof);
      n++;
    end
    steps = n;
    wx = int'(x & 4095);
    wy = int'(y & 4095);
  endtask

  task automatic check_dut(input int d, input int ewx, input int ewy, input int ef,
                           input int es, input int el, input int eq[$],
                           input int b_end, input int b_rd);
    int nrd;
    nrd = ((d == 0) ? rdq0.size() : rdq1.size()) - b_rd;
    check_val($sformatf("d%0d_end_pulses", d), n_end[d] - b_end, 1);
    check_val($sformatf("d%0d_latency", d), lat[d], el);
    check_val($sformatf("d%0d_wallX", d), obs_wx[d], ewx);
    check_val($sformatf("d%0d_wallY", d), obs_wy[d], ewy);
    check_val($sformatf("d%0d_wall_found", d), obs_f[d], ef);
    check_val($sformatf("d%0d_step_count", d), obs_s[d], es);
    check_val($sformatf("d%0d_num_reads", d), nrd, eq.size());
    for (int k = 0; k < eq.size() && k < nrd; k++)
      check_val($sformatf("d%0d_read%0d", d, k),
                (d == 0) ? rdq0[b_rd + k] : rdq1[b_rd + k], eq[k]);
    check_val($sformatf("d%0d_busy_after", d), (d == 0) ? rif0.busy : rif1.busy, 0);
    check_val($sformatf("d%0d_held_found", d),
              (d == 0) ? rif0.wall_found : rif1.wall_found, ef);
    check_val($sformatf("d%0d_held_steps", d),
              (d == 0) ? rif0.step_count : rif1.step_count, es);
  endtask

  task automatic start_both(input bit mode, input bit dir, input int slope,
                            input int px, input int py);
    @(negedge clock);
    rif0.begin_calc = 1'b1; rif1.begin_calc = 1'b1;
    rif0.mode = mode; rif1.mode = mode;
    rif0.dir_pos = dir; rif1.dir_pos = dir;
    rif0.slope = 20'(slope); rif1.slope = 20'(slope);
    rif0.playerX = 12'(px); rif1.playerX = 12'(px);
    rif0.playerY = 12'(py); rif1.playerY = 12'(py);
    @(negedge clock);
    c0 = cyc;
    rif0.begin_calc = 1'b0; rif1.begin_calc = 1'b0;
    rif0.mode = 1'($urandom); rif1.mode = 1'($urandom);
    rif0.dir_pos = 1'($urandom); rif1.dir_pos = 1'($urandom);
    rif0.slope = 20'($urandom); rif1.slope = 20'($urandom);
    rif0.playerX = 12'($urandom); rif1.playerX = 12'($urandom);
    rif0.playerY = 12'($urandom); rif1.playerY = 12'($urandom);
  endtask

  task automatic run_ray(input bit mode, input bit dir, input int slope,
                         input int px, input int py, input bit poke);
    int wx0, wy0, f0, s0, l0, wx1, wy1, f1, s1, l1;
    int eq0[$];
    int eq1[$];
    int b_end0, b_end1, b_rd0, b_rd1;
    ref_model(mode, dir, slope, px, py, LIM0, wx0, wy0, f0, s0, l0, eq0);
    ref_model(mode, dir, slope, px, py, LIM1, wx1, wy1, f1, s1, l1, eq1);
    b_end0 = n_end[0]; b_end1 = n_end[1];
    b_rd0 = rdq0.size(); b_rd1 = rdq1.size();
    start_both(mode, dir, slope, px, py);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (poke) rif0.begin_calc = (i == 2) || rif0.end_calc;
      if (n_end[0] != b_end0 && n_end[1] != b_end1) break;
    end
    @(negedge clock);
    rif0.begin_calc = 1'b0;
    repeat (3) @(negedge clock);
    check_dut(0, wx0, wy0, f0, s0, l0, eq0, b_end0, b_rd0);
    check_dut(1, wx1, wy1, f1, s1, l1, eq1, b_end1, b_rd1);
  endtask

  task automatic clear_map();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        map_mem[r][c] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, rif0.busy, 0);
    check_val({tag, "_end_calc"}, rif0.end_calc, 0);
    check_val({tag, "_wallX"}, rif0.wallX, 0);
    check_val({tag, "_wallY"}, rif0.wallY, 0);
    check_val({tag, "_wall_found"}, rif0.wall_found, 0);
    check_val({tag, "_step_count"}, rif0.step_count, 0);
    check_val({tag, "_rd_en"}, rd0, 0);
    check_val({tag, "_col_row"}, {col0, row0}, 0);
  endtask

  initial begin
    int sl, px, py;
    bit md, dr, pk;
    rif0.begin_calc = 1'b0; rif1.begin_calc = 1'b0;
    rif0.mode = 1'b0; rif1.mode = 1'b0;
    rif0.dir_pos = 1'b0; rif1.dir_pos = 1'b0;
    rif0.slope = '0; rif1.slope = '0;
    rif0.playerX = '0; rif1.playerX = '0;
    rif0.playerY = '0; rif1.playerY = '0;
    n_end = '{0, 0};
    lat = '{0, 0};
    clear_map();

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Wall right at the first crossing
    map_mem[0][1] = 1'b1;
    run_ray(1'b0, 1'b0, 0, 96, 96, 1'b0);
    check_val("t1_wallX", obs_wx[0], 96);
    check_val("t1_wallY", obs_wy[0], 63);
    check_val("t1_found", obs_f[0], 1);
    check_val("t1_latency", lat[0], 5);

    // Same ray, empty map: leaves through the top edge
    clear_map();
    run_ray(1'b0, 1'b0, 0, 96, 96, 1'b0);
    check_val("t2_wallY", obs_wy[0], 4095);
    check_val("t2_steps", obs_s[0], 1);
    check_val("t2_found", obs_f[0], 0);

    // Diagonal vertical-line ray hitting (192,192)
    map_mem[3][3] = 1'b1;
    run_ray(1'b1, 1'b1, 256, 96, 96, 1'b0);
    check_val("t3_wallX", obs_wx[0], 192);
    check_val("t3_wallY", obs_wy[0], 192);
    check_val("t3_steps", obs_s[0], 1);

    // Step limit on the MAX_STEPS=2 instance
    clear_map();
    run_ray(1'b0, 1'b1, 0, 32, 10, 1'b0);
    check_val("t4_lim_steps", obs_s[1], 2);
    check_val("t4_lim_found", obs_f[1], 0);
    check_val("t4_lim_wallY", obs_wy[1], 192);

    // Extra begin_calc mid-run and on the end_calc cycle
    map_mem[3][3] = 1'b1;
    run_ray(1'b1, 1'b1, 256, 96, 96, 1'b1);
    check_val("t5_wallX", obs_wx[0], 192);

    // Reset while waiting on the map
    clear_map();
    map_mem[0][1] = 1'b1;
    start_both(1'b0, 1'b0, 0, 96, 96);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rd0) break;
    end
    check_val("t6_read_seen", rd0, 1);
    @(negedge clock);
    #1 resetn = 1'b0;
    #1 check_idle_outputs("t6_async");
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    run_ray(1'b0, 1'b0, 0, 96, 96, 1'b0);
    check_val("t6_fresh_found", obs_f[0], 1);
    check_val("t6_fresh_latency", lat[0], 5);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          map_mem[r][c] = ($urandom_range(0, 3) == 0);
      md = 1'($urandom);
      dr = 1'($urandom);
      pk = ($urandom_range(0, 3) == 0);
      sl = int'($urandom_range(0, 1536)) - 768;
      px = int'($urandom_range(0, 511));
      py = int'($urandom_range(0, 511));
      run_ray(md, dr, sl, px, py, pk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ray_grid_stepper.md
Name: ray_grid_stepper

Overview:
- Parametrised grid-line wall finder for the raycast renderer. One instance replaces both the horizontal-only and the vertical intersection finders.
- Per ray, it computes the first crossing of a grid line on the stepped axis, then steps cell by cell and queries the maze map at each crossing.
- It stops on a wall, on leaving the maze, or on reaching a step limit, and reports the hit point and the step count.
- It sits between the per-column ray sequencer, which supplies slope and direction from its trig LUT, and the distance/projection stage.

Parameters:
- W, 12, width of unsigned world coordinates.
- CELL_LOG2, 6, log2 of grid cell size (64 units).
- MAP_COLS, 8, maze width in cells.
- MAP_ROWS, 8, maze height in cells.
- FRAC, 8, fractional bits of slope.
- MAX_STEPS, 16, maximum grid steps after the first intersection.
- MAP_LAT, 1, fixed map read latency in cycles (>=1).

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- begin_calc  in  1  start request; sampled only in S_WAIT.
- mode  in  1  0 = horizontal lines (step Y), 1 = vertical lines (step X).
- dir_pos  in  1  ray moves toward increasing stepped coordinate.
- slope  in  W+FRAC signed  dOther/dStepped, Q(W).FRAC.
- playerX, playerY  in  W  player position.
- map_rd_en  out  1  map read strobe, one cycle.
- map_col  out  clog2(MAP_COLS)  cell column.
- map_row  out  clog2(MAP_ROWS)  cell row.
- map_wall  in  1  wall bit, valid MAP_LAT cycles after map_rd_en.
- wallX, wallY  out  W  last tested intersection.
- wall_found  out  1  end reason is a wall.
- step_count  out  clog2(MAX_STEPS+1)  steps taken.
- busy  out  1  high outside S_WAIT.
- end_calc  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state) -> S_WAIT. All outputs 0, all registers cleared.
- Operands: playerX, playerY, mode, dir_pos and slope are latched on the accepting edge. They may change freely afterwards.
- S_WAIT: begin_calc=1 -> S_FIRST.
- S_FIRST (1 cycle). S = stepped coordinate, O = other coordinate, B = (S>>CELL_LOG2)<<CELL_LOG2.
  - S1 = dir_pos ? B+2^CELL_LOG2 : B-1.
  - O1 = O + (((S1-S)*slope) >>> FRAC).
  - Internal math is signed W+2 bits; the product is truncated after the shift.
- S_OFFSET (1 cycle):
  - dS = dir_pos ? +2^CELL_LOG2 : -2^CELL_LOG2.
  - dO = (dir_pos ? slope : -slope) <<< CELL_LOG2 >>> FRAC.
  - Shift-only; no multiplier is used.
- S_BOUND (1 cycle):
  - If either coordinate is <0, X >= MAP_COLS<<CELL_LOG2, or Y >= MAP_ROWS<<CELL_LOG2 -> S_DONE, wall_found=0.
  - Else assert map_rd_en with col = X>>CELL_LOG2, row = Y>>CELL_LOG2 -> S_MAP_WAIT.
- S_MAP_WAIT: lasts exactly MAP_LAT cycles; map_wall is sampled on the last one.
  - 1 -> S_DONE, wall_found=1.
  - 0 and step_count==MAX_STEPS -> S_DONE, wall_found=0.
  - Else -> S_STEP.
- S_STEP (1 cycle): S += dS, O += dO, step_count++ -> S_BOUND.
- S_DONE (1 cycle):
  - end_calc=1, then -> S_WAIT.
  - wallX/wallY hold the last computed intersection, including the out-of-bounds point.
  - wall_found and step_count stay held until the next accepted begin_calc, which clears them.
- Latency from the accepting edge to end_calc:
  - Hit at first intersection: 4+MAP_LAT cycles.
  - Each additional step: +2+MAP_LAT cycles.
- Busy handling: begin_calc while busy is ignored (not queued). begin_calc in the same cycle as end_calc is also ignored.
- Bound checking precedes the map read, so map_col/map_row never index outside the map.

Decomposition:
- Shared package ray_pkg holds:
  - state localparams (S_WAIT, S_FIRST, S_OFFSET, S_BOUND, S_MAP_WAIT, S_STEP, S_DONE);
  - the MODE_HORIZ/MODE_VERT constants;
  - a CELL_SIZE function.
- Control FSM and datapath are separate sub-modules: ray_stepper_ctrl (states, latency counter, step limit) and the datapath inside ray_grid_stepper.

Test Plan:
All scenarios use defaults: 64-unit cells, 8x8 map, FRAC=8, MAP_LAT=1.
1. Player (96,96), mode 0, dir_pos 0, slope 0, wall at col1 row0 -> one read at (1,0); end_calc 5 cycles after accept; wallX=96, wallY=63, wall_found=1, step_count=0.
2. Same ray, empty map -> reads (1,0); step gives Y=-1, out of bounds; end_calc with wall_found=0, step_count=1, wallY=-1 truncated (4095).
3. Player (96,96), mode 1, dir_pos 1, slope 256 (1.0), wall at col3 row3 -> intersections (128,128), (192,192), (256,256); end_calc at (192,192)? No: the wall hits at col3 row3 = (192,192) on step 1; wall_found=1, step_count=1.
4. MAX_STEPS=2, mode 0, dir_pos 1, slope 0, player (32,10), no walls in column 0 -> 3 reads (rows 1,2,3), end with wall_found=0, step_count=2.
5. begin_calc pulsed again mid-run, and in the end_calc cycle -> ignored; the original result is unchanged and there is exactly one end_calc.
6. resetn low during S_MAP_WAIT -> immediate S_WAIT with all outputs 0. The next begin_calc produces a correct fresh result with no stale map_wall use.
